fwd_hazard_ctrl: RTL
====================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port id_valid, input, 1, ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs1 / id_rs2, input, REG_ADDR_W, ID source registers.
REQ-007 SHALL have ports id_rs1_used / id_rs2_used, input, 1, the matching source is actually read.
REQ-008 SHALL have port id_rd, input, REG_ADDR_W, ID destination register.
REQ-009 SHALL have ports id_reg_write / id_mem_read, input, 1, ID writes rd / ID is a load.
REQ-010 SHALL have port flush, input, 1, EX-resolved redirect that kills the ID instruction.
REQ-011 SHALL have port id_stall, output, 1, combinational; hold PC and IF/ID.
REQ-012 SHALL have ports ex_fwd_sel_a / ex_fwd_sel_b, output, 2, registered selects for the 3:1 EX operand muxes: 00 register-file value, 01 MEM-stage result, 10 WB-stage result; 11 never driven.
REQ-013 SHALL have port ex_bubble, output, 1, registered; EX holds a bubble.
REQ-014 SHALL have port stall_cnt, output, CNT_W, count of stall cycles.

Function
REQ-015 SHALL keep three tracking entries ex_q, mem_q and wb_q, each holding {valid, rd, reg_write, mem_read}.
REQ-016 SHALL, every cycle, shift mem_q<=ex_q and wb_q<=mem_q unconditionally.
REQ-017 SHALL load ex_q with the ID entry when id_valid=1, id_stall=0 and flush=0; otherwise it SHALL load ex_q with a bubble (valid=0) and set ex_bubble=1 for that cycle.
REQ-018 SHALL define a match as entry.valid & entry.reg_write & entry.rd!=0 & rd==rsN & idN_used; register x0 SHALL never match.
REQ-019 SHALL, when loading a real ID entry, register ex_fwd_sel_N=01 if ex_q matches rsN, else 10 if mem_q matches, else 00; ex_q has priority (youngest producer wins).
REQ-020 SHALL register ex_fwd_sel_a/b=00 whenever a bubble is loaded.
REQ-021 SHALL assert id_stall on a load-use hazard: id_valid=1 and ex_q matches rs1 or rs2 with ex_q.mem_read=1; this gives exactly one stall cycle, after which the load is in mem_q and forwarding selects 10.
REQ-022 SHALL force id_stall=0 when flush=1; flush has priority over stall.
REQ-023 SHALL leave a producer already in wb_q during the consumer's ID cycle to register-file write-through and not forward it.
REQ-024 SHALL increment stall_cnt each cycle id_stall=1 and SHALL saturate at all-ones without wrapping.

Reset
REQ-025 SHALL, while rst=1 and independent of clk, clear all entries to invalid and set ex_fwd_sel_a/b=00, ex_bubble=1 and stall_cnt=0; id_stall SHALL evaluate to 0.
REQ-026 SHALL, on reset asserted mid-stall, drop the pending stall; the first cycle after release SHALL be hazard-free.

Configuration
REQ-027 SHALL use macro FWD_HAZARD_FORWARDING_EN; when defined, REQ-019 and REQ-021 apply.
REQ-028 SHALL, with FWD_HAZARD_FORWARDING_EN undefined, hold ex_fwd_sel_a/b at 00 and assert id_stall whenever ex_q or mem_q matches any used source (full interlock, up to 2 stall cycles); all other rules are unchanged.

Verification
REQ-029 SHALL check this case: ADD x5 then back-to-back SUB rs1=x5 -> SUB enters EX with ex_fwd_sel_a=01, id_stall never 1.
REQ-030 SHALL check this case: ADD x5, NOP, OR rs2=x5 -> OR enters EX with ex_fwd_sel_b=10.
REQ-031 SHALL check this case: LW x7 then ADD rs1=x7 -> id_stall=1 for exactly 1 cycle, ex_bubble=1 next cycle, ADD enters EX with ex_fwd_sel_a=10, stall_cnt=1.
REQ-032 SHALL check this case: LW x7, ADD rs1=x7 with flush=1 in the hazard cycle -> id_stall=0, bubble loaded, stall_cnt unchanged.
REQ-033 SHALL check this case: ADD x0 then SUB rs1=x0 -> ex_fwd_sel_a=00, no stall.
REQ-034 SHALL check this case: macro undefined, ADD x5 then SUB rs1=x5 -> id_stall=1 for 2 cycles, ex_fwd_sel_a=00, stall_cnt=2; also force stall_cnt to all-ones and verify it holds under further stalls.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use hazard control for a 5-stage in-order pipeline.
// Optional macro FWD_HAZARD_FORWARDING_EN enables forwarding; the default build is a full interlock.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  id_stall,
  output logic [1:0]            ex_fwd_sel_a,
  output logic [1:0]            ex_fwd_sel_b,
  output logic                  ex_bubble,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } entry_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  entry_t           ex_q, ex_d, mem_q, wb_q;
  logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic             bubble_q, bubble_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic             stall_c, load_c;
  logic             track_unused;

  // x0 is hard-wired zero, so a write to it never produces a forwardable value
  function automatic logic entry_match(input entry_t e, input logic [REG_ADDR_W-1:0] rs,
                                       input logic used);
    return e.valid && e.reg_write && (e.rd != '0) && (e.rd == rs) && used;
  endfunction

  // Hazard detection; flush kills the ID instruction so it can never be stalled
  always_comb begin
    hit_ex_a  = entry_match(ex_q,  id_rs1, id_rs1_used);
    hit_ex_b  = entry_match(ex_q,  id_rs2, id_rs2_used);
    hit_mem_a = entry_match(mem_q, id_rs1, id_rs1_used);
    hit_mem_b = entry_match(mem_q, id_rs2, id_rs2_used);
`ifdef FWD_HAZARD_FORWARDING_EN
    stall_c = id_valid && ex_q.mem_read && (hit_ex_a || hit_ex_b);
`else
    stall_c = id_valid && (hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b);
`endif
    if (flush || rst) stall_c = 1'b0;
  end

  // Next EX entry, operand selects and saturating stall counter
  always_comb begin
    load_c   = id_valid && !stall_c && !flush;
    ex_d     = '0;
    sel_a_d  = SEL_RF;
    sel_b_d  = SEL_RF;
    bubble_d = 1'b1;
    cnt_d    = cnt_q;
    if (load_c) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      bubble_d       = 1'b0;
`ifdef FWD_HAZARD_FORWARDING_EN
      // The youngest producer holds the most recent value of the register
      sel_a_d = hit_ex_a ? SEL_MEM : (hit_mem_a ? SEL_WB : SEL_RF);
      sel_b_d = hit_ex_b ? SEL_MEM : (hit_mem_b ? SEL_WB : SEL_RF);
`endif
    end
    if (stall_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      sel_a_q  <= SEL_RF;
      sel_b_q  <= SEL_RF;
      bubble_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
    end
  end

  // WB-stage producers retire through register-file write-through and need no forwarding
  assign track_unused = ^{wb_q, mem_q.mem_read, ex_q.mem_read};

  assign id_stall     = stall_c;
  assign ex_fwd_sel_a = sel_a_q;
  assign ex_fwd_sel_b = sel_b_q;
  assign ex_bubble    = bubble_q;
  assign stall_cnt    = cnt_q;

endmodule
